// File: rtl/pll_dyn_pkg.sv
// pll_dyn_pkg: shared state type, divider width and helpers
// for the PLL dynamic divider sequencer.
package pll_dyn_pkg;

  typedef enum logic [1:0] {
    RST_PLL,
    WAIT_LOCK,
    LOCKED,
    FAIL
  } state_e;

  localparam int DIV_W = 6;

  // Counter width for a counter that runs 0..n-1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The PLL divider ports take the bitwise-inverted value.
  function automatic logic [DIV_W-1:0] enc_div(
    input logic [DIV_W-1:0] v
  );
    return ~v;
  endfunction

endpackage

// File: rtl/pll_dyn_ctrl_key_debounce.sv
// key_debounce: 2-FF synchronizer plus debounce of a raw key.
// Ports: clk, rst (sync, active-high), key_i (async), press_o (1-cycle on press).
module key_debounce
  import pll_dyn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          k1_q, k1_d;
  logic          k2_q, k2_d;
  logic          lvl_q, lvl_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced key disagrees with the
  // debounced level, so any bounce back restarts it from zero.
  always_comb begin
    k1_d    = key_i;
    k2_d    = k1_q;
    lvl_d   = lvl_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (k2_q != lvl_q) begin
      if (cnt_q == LAST) begin
        lvl_d   = k2_q;
        press_d = k2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k1_q    <= 1'b0;
      k2_q    <= 1'b0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: sequences PLL divider presets, reset and lock qualification.
// Ports: clk, rst, key_i, lock_i in; fdiv_o, idiv_o, pll_reset_o, sel_o, locked_o, busy_o, err_o out.
module pll_dyn_ctrl
  import pll_dyn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int RESET_CYCLES    = 16,
  parameter int LOCK_STABLE     = 64,
  parameter int LOCK_TIMEOUT    = 27000,
  parameter int MAX_RETRY       = 3,
  parameter int FDIV_A          = 9,
  parameter int IDIV_A          = 2,
  parameter int FDIV_B          = 12,
  parameter int IDIV_B          = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_i,
  input  logic             lock_i,
  output logic [DIV_W-1:0] fdiv_o,
  output logic [DIV_W-1:0] idiv_o,
  output logic             pll_reset_o,
  output logic             sel_o,
  output logic             locked_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int RCW = cnt_w(RESET_CYCLES);
  localparam int SCW = cnt_w(LOCK_STABLE);
  localparam int TCW = cnt_w(LOCK_TIMEOUT);
  localparam int YW  = cnt_w(MAX_RETRY + 1);

  localparam logic [RCW-1:0] R_LAST = RCW'(RESET_CYCLES - 1);
  localparam logic [SCW-1:0] S_LAST = SCW'(LOCK_STABLE - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(LOCK_TIMEOUT - 1);
  localparam logic [YW-1:0]  Y_MAX  = YW'(MAX_RETRY);

  localparam logic [DIV_W-1:0] FA = DIV_W'(FDIV_A);
  localparam logic [DIV_W-1:0] IA = DIV_W'(IDIV_A);
  localparam logic [DIV_W-1:0] FB = DIV_W'(FDIV_B);
  localparam logic [DIV_W-1:0] IB = DIV_W'(IDIV_B);

  logic             press;
  logic             l1_q, l2_q;
  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             pend_q, pend_d;
  logic [YW-1:0]    retry_q, retry_d, retry_nx;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic [SCW-1:0]   scnt_q, scnt_d;
  logic [TCW-1:0]   tcnt_q, tcnt_d;
  logic [DIV_W-1:0] fdiv_q, fdiv_d;
  logic [DIV_W-1:0] idiv_q, idiv_d;
  logic             prst_q, prst_d;
  logic             lk_q, lk_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             go;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk    (clk),
    .rst    (rst),
    .key_i  (key_i),
    .press_o(press)
  );

  assign go       = press | pend_q;
  assign retry_nx = retry_q + YW'(1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    retry_d = retry_q;
    rcnt_d  = '0;
    scnt_d  = '0;
    tcnt_d  = '0;
    unique case (state_q)
      RST_PLL: begin
        if (press) pend_d = 1'b1;
        if (rcnt_q == R_LAST) state_d = WAIT_LOCK;
        else rcnt_d = rcnt_q + RCW'(1);
      end
      WAIT_LOCK: begin
        if (press) pend_d = 1'b1;
        // Lock is tested first so it wins a tie with timeout.
        if (l2_q && scnt_q == S_LAST) begin
          state_d = LOCKED;
          retry_d = '0;
        end else if (tcnt_q == T_LAST) begin
          retry_d = retry_nx;
          state_d = (retry_nx < Y_MAX) ? RST_PLL : FAIL;
        end else begin
          tcnt_d = tcnt_q + TCW'(1);
          if (l2_q) scnt_d = scnt_q + SCW'(1);
        end
      end
      LOCKED: begin
        // A press outranks a simultaneous lock loss.
        if (go) begin
          sel_d   = ~sel_q;
          pend_d  = 1'b0;
          state_d = RST_PLL;
        end else if (!l2_q) begin
          state_d = WAIT_LOCK;
        end
      end
      FAIL: begin
        if (go) begin
          sel_d   = ~sel_q;
          pend_d  = 1'b0;
          retry_d = '0;
          state_d = RST_PLL;
        end
      end
    endcase
  end

  always_comb begin
    fdiv_d = enc_div(sel_d ? FB : FA);
    idiv_d = enc_div(sel_d ? IB : IA);
    prst_d = (state_d == RST_PLL);
    lk_d   = (state_d == LOCKED);
    busy_d = (state_d == RST_PLL) || (state_d == WAIT_LOCK);
    err_d  = (state_d == FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l1_q    <= 1'b0;
      l2_q    <= 1'b0;
      state_q <= RST_PLL;
      sel_q   <= 1'b0;
      pend_q  <= 1'b0;
      retry_q <= '0;
      rcnt_q  <= '0;
      scnt_q  <= '0;
      tcnt_q  <= '0;
      fdiv_q  <= enc_div(FA);
      idiv_q  <= enc_div(IA);
      prst_q  <= 1'b1;
      lk_q    <= 1'b0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      l1_q    <= lock_i;
      l2_q    <= l1_q;
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      retry_q <= retry_d;
      rcnt_q  <= rcnt_d;
      scnt_q  <= scnt_d;
      tcnt_q  <= tcnt_d;
      fdiv_q  <= fdiv_d;
      idiv_q  <= idiv_d;
      prst_q  <= prst_d;
      lk_q    <= lk_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign fdiv_o      = fdiv_q;
  assign idiv_o      = idiv_q;
  assign pll_reset_o = prst_q;
  assign sel_o       = sel_q;
  assign locked_o    = lk_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: doc/pll_dyn_ctrl.md
Name: pll_dyn_ctrl

Overview:
- Sequencer that owns the dynamic divider inputs of one Gowin PLLVR: fdiv, idiv and reset_p, plus the lock output coming back.
- A debounced key press toggles between two divider presets, holds the PLL in reset, then qualifies lock with a timeout and bounded retry.
- Reports clean status to the top level: locked, busy, error, active preset.
- Replaces ad-hoc key-to-fdiv wiring in the board tops.

Parameters:
- DEBOUNCE_CYCLES, 270000: cycles key_i must be stable before the debounced level changes (10 ms at 27 MHz).
- RESET_CYCLES, 16: cycles pll_reset_o is held high per attempt.
- LOCK_STABLE, 64: consecutive synced-lock-high cycles required to declare lock.
- LOCK_TIMEOUT, 27000: cycles in WAIT_LOCK before an attempt fails.
- MAX_RETRY, 3: failed attempts allowed before entering FAIL.
- FDIV_A, 9: preset A feedback divider value, non-inverted, 0..63.
- IDIV_A, 2: preset A input divider value, non-inverted, 0..63.
- FDIV_B, 12: preset B feedback divider value.
- IDIV_B, 5: preset B input divider value.

Ports:
- clk, input, 1: system clock (board oscillator).
- rst, input, 1: reset; synchronous, active-high.
- key_i, input, 1: raw pushbutton, asynchronous, 1 = pressed.
- lock_i, input, 1: PLL lock_o, asynchronous.
- fdiv_o, output, 6: to PLL fdiv; bitwise-inverted encoding.
- idiv_o, output, 6: to PLL idiv; bitwise-inverted encoding.
- pll_reset_o, output, 1: to PLL reset_p.
- sel_o, output, 1: active preset, 0 = A, 1 = B.
- locked_o, output, 1: qualified lock.
- busy_o, output, 1: high in RST_PLL and WAIT_LOCK.
- err_o, output, 1: high in FAIL.

Behaviour:
- Reset values:
  - state = RST_PLL, sel_o = 0, fdiv_o = ~FDIV_A, idiv_o = ~IDIV_A.
  - pll_reset_o = 1, locked_o = 0, busy_o = 1, err_o = 0.
  - retry count = 0, pending = 0.
  - Debounced key = 0; both synchronizers cleared.
- Synchronizers:
  - key_i and lock_i each pass through a 2-FF synchronizer; all logic uses the synced versions.
  - Synchronizer latency: 2 cycles.
- Debounce:
  - The counter restarts whenever synced key differs from the debounced level.
  - The debounced level takes the new value when the counter reaches DEBOUNCE_CYCLES-1.
  - A press event is a one-cycle pulse on the debounced 0->1 transition. Release generates no event.
- All outputs are registered. Divider outputs always equal ~preset(sel_o), 6 bits, with no arithmetic.
- State RST_PLL:
  - pll_reset_o = 1.
  - Count RESET_CYCLES, then go to WAIT_LOCK.
  - pll_reset_o is low from the first WAIT_LOCK cycle.
- State WAIT_LOCK:
  - A stable counter counts consecutive synced-lock-high cycles and clears on any low cycle.
  - A timeout counter counts every cycle.
  - Stable counter reaches LOCK_STABLE -> LOCKED; locked_o goes 1 on entry; retry count cleared.
  - Timeout reaches LOCK_TIMEOUT first -> increment retry count, then:
    - retry count < MAX_RETRY: go to RST_PLL.
    - otherwise: go to FAIL.
  - If both conditions occur in the same cycle, lock wins.
- State LOCKED:
  - Synced lock low for one cycle -> locked_o = 0 and go to WAIT_LOCK with counters cleared. This is loss of lock; no new reset is issued.
  - Press event (or pending = 1): toggle sel_o, update dividers and enter RST_PLL, all on the same edge. locked_o drops the same cycle. pending cleared.
  - Press event and lock loss in the same cycle: the press wins.
- State FAIL:
  - err_o = 1, pll_reset_o = 0, dividers held.
  - Only a press event (or pending) leaves FAIL: toggle sel_o, clear retry count, enter RST_PLL.
- Press events during RST_PLL or WAIT_LOCK:
  - Set pending; the queue is one deep, so extra presses are dropped.
  - Pending is acted on at entry to LOCKED or FAIL, on the cycle after entry.
- Counter widths: sized with $clog2 of their limits. No counter wraps; each saturates at its terminal compare.
- rst mid-operation: returns to RST_PLL with preset A regardless of state.

Decomposition:
- Package pll_dyn_pkg holds:
  - State enum: RST_PLL, WAIT_LOCK, LOCKED, FAIL.
  - Divider width constant DIV_W = 6.
  - Helper function enc_div(v) = ~v.
- One sub-module, key_debounce: synchronizer, debounce counter, press-pulse output, parameterised by DEBOUNCE_CYCLES.
- The lock synchronizer stays inline.

Test Plan:
Bench parameters: DEBOUNCE=8, RESET=4, STABLE=4, TIMEOUT=20, RETRY=2.
- Lock path: rst for 2 cycles, then lock_i tied 1 -> pll_reset_o high for 4 cycles; locked_o=1 after 2 sync + 4 stable cycles; fdiv_o=6'b110110, idiv_o=6'b111101.
- Preset switch: in LOCKED, key high for 12 cycles -> one press event; sel_o=1, fdiv_o=6'b110011, idiv_o=6'b111010, pll_reset_o pulses 4 cycles, then relock; a second press returns to preset A.
- Bounce rejection: key toggles every 3 cycles for 30 cycles -> no press event; sel_o unchanged.
- Retry and fail: lock_i held 0 -> two RST_PLL/WAIT_LOCK rounds of 20 cycles each, then err_o=1, busy_o=0; a press then gives sel toggle, err_o=0, RST_PLL.
- Lock loss: in LOCKED drop lock_i 1 cycle -> locked_o=0, no pll_reset_o pulse; lock restored -> locked_o=1 after 4 stable cycles.
- Pending and mid-operation reset: a press during WAIT_LOCK -> once locked, an automatic toggle and reset the next cycle; rst asserted in WAIT_LOCK with sel=1 -> sel_o=0 and RST_PLL on the next edge.
